// File: rtl/setpoint_ramp.sv
// Slew-limited setpoint source for the first-order CIC interpolator.
//
// The host writes a signed target. Once every 2**span clock cycles the block moves d_out toward
// that target by at most max_step and raises a one-cycle strobe. The new d_out and the strobe
// appear on the same edge, so the interpolator samples a value that then stays stable for the
// whole interval.
//
// Ports
//   clk        in   1    single clock, rising edge
//   rst        in   1    asynchronous active-high reset
//   target     in   dw   signed requested setpoint
//   target_we  in   1    load target into the internal target register on this edge
//   max_step   in   sw   unsigned maximum |change| of d_out per strobe
//   hold       in   1    freeze d_out at strobes; the strobe itself keeps running
//   d_out      out  dw   signed current setpoint
//   strobe     out  1    one-cycle update pulse, period 2**span
//   busy       out  1    high while d_out differs from the target register
module setpoint_ramp #(
  parameter int unsigned span = 6,
  parameter int unsigned dw   = 18,
  parameter int unsigned sw   = 12   // must be smaller than dw
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [dw-1:0] target,
  input  logic                 target_we,
  input  logic        [sw-1:0] max_step,
  input  logic                 hold,
  output logic signed [dw-1:0] d_out,
  output logic                 strobe,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StRamp, StHeld} state_e;

  state_e                r_state, w_state_d;
  logic       [span-1:0] r_cnt;
  logic                  r_strobe;
  logic                  r_busy;
  logic signed [dw-1:0]  r_tgt, w_tgt_d;
  logic signed [dw-1:0]  r_dout, w_dout_d;

  logic                  w_wrap;
  logic signed [dw:0]    w_err;
  logic        [dw:0]    w_err_abs;
  logic        [dw:0]    w_step_ext;
  logic        [dw-1:0]  w_step_dw;
  logic                  w_busy_d;

  // The strobe register rises on the edge where the counter wraps all-ones -> 0.
  assign w_wrap = &r_cnt;

  // Error is formed one bit wider so that tgt - d_out can never wrap.
  assign w_err      = {r_tgt[dw-1], r_tgt} - {r_dout[dw-1], r_dout};
  assign w_err_abs  = w_err[dw] ? $unsigned(-w_err) : $unsigned(w_err);
  assign w_step_ext = {{(dw + 1 - sw){1'b0}}, max_step};
  assign w_step_dw  = {{(dw - sw){1'b0}}, max_step};

  // A write coincident with the strobe edge lands in r_tgt on that edge; the step on that edge
  // still reads the old r_tgt.
  assign w_tgt_d = target_we ? target : r_tgt;

  // A full step only happens when |err| > max_step, so the result stays strictly between
  // d_out and the target and the dw-bit add/subtract cannot overflow.
  always_comb begin
    w_dout_d = r_dout;
    if (w_wrap && !hold) begin
      if (w_err_abs <= w_step_ext) begin
        w_dout_d = r_tgt;
      end else if (w_err[dw]) begin
        w_dout_d = r_dout - w_step_dw;
      end else begin
        w_dout_d = r_dout + w_step_dw;
      end
    end
  end

  // busy reflects the values that will be held after this edge.
  assign w_busy_d = (w_tgt_d != w_dout_d);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (hold) begin
          w_state_d = StHeld;
        end else if (w_busy_d) begin
          w_state_d = StRamp;
        end
      end
      StRamp: begin
        if (hold) begin
          w_state_d = StHeld;
        end else if (!w_busy_d) begin
          w_state_d = StIdle;
        end
      end
      StHeld: begin
        if (!hold) begin
          w_state_d = w_busy_d ? StRamp : StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_strobe <= 1'b0;
      r_busy   <= 1'b0;
      r_tgt    <= '0;
      r_dout   <= '0;
      r_state  <= StIdle;
    end else begin
      r_cnt    <= r_cnt + span'(1);
      r_strobe <= w_wrap;
      r_busy   <= w_busy_d;
      r_tgt    <= w_tgt_d;
      r_dout   <= w_dout_d;
      r_state  <= w_state_d;
    end
  end

  assign d_out  = r_dout;
  assign strobe = r_strobe;
  assign busy   = r_busy;

endmodule
